// File: rtl/dac_pkg.sv
// Shared definitions for the DAC sample feeder: FSM encoding, default widths
// and the rate-counter width helper.
package dac_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } feeder_state_e;

  localparam int unsigned DEFAULT_BW = 16;

  // Width of a counter covering 0..rate_div-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned rate_div);
    return (rate_div <= 2) ? 1 : $clog2(rate_div);
  endfunction

endpackage

// File: rtl/dac_sync_fifo.sv
// Synchronous FIFO with synchronous clear; the head is read from storage, so a
// word written on an edge is never visible on rd_data_o before that edge.
module dac_sync_fifo
  import dac_pkg::*;
#(
  parameter int unsigned BW    = DEFAULT_BW,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [BW-1:0]            wr_data_i,
  output logic [BW-1:0]            rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i && !rst_i) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers bursty PCM input and releases one sample every RATE_DIV clocks with
// a one-cycle strobe into the FIR filter; flags underruns.
module dac_sample_feeder
  import dac_pkg::*;
#(
  parameter int unsigned BW       = DEFAULT_BW,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PREFILL  = 4,
  parameter int unsigned RATE_DIV = 64
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic [BW-1:0]            in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  input  logic                     clr_underflow_i,
  output logic [BW-1:0]            sample_o,
  output logic                     sample_strobe_o,
  output logic                     underflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned CNT_W = cnt_width(RATE_DIV);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  feeder_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic             push;
  logic             pop_c;
  logic             uflow_evt_c;
  logic [BW-1:0]    head;
  logic [LVL_W-1:0] level;

  // Free-running output-rate counter, independent of state and flush.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick       = (cnt_q == CNT_W'(RATE_DIV - 1));
  assign in_ready_o = !rst_i && !flush_i && (level < LVL_W'(DEPTH));
  assign push       = in_valid_i && in_ready_o;

  dac_sync_fifo #(
    .BW    (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .push_i    (push),
    .pop_i     (pop_c),
    .wr_data_i (in_data_i),
    .rd_data_o (head),
    .level_o   (level)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the pop / underrun decisions for this edge.
  always_comb begin
    state_d     = state_q;
    pop_c       = 1'b0;
    uflow_evt_c = 1'b0;
    case (state_q)
      PRIME: begin
        if (level >= LVL_W'(PREFILL)) state_d = RUN;
      end
      RUN: begin
        if (tick) begin
          if (level != '0) pop_c = !flush_i;
          else             uflow_evt_c = 1'b1;
        end
      end
      default: state_d = PRIME;
    endcase
    if (flush_i) state_d = PRIME;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sample_o        <= '0;
      sample_strobe_o <= 1'b0;
      underflow_o     <= 1'b0;
    end else begin
      sample_strobe_o <= tick;
      if (flush_i)    sample_o <= '0;
      else if (pop_c) sample_o <= head;
      // A fresh underrun on the clearing edge takes precedence.
      if (uflow_evt_c)          underflow_o <= 1'b1;
      else if (clr_underflow_i) underflow_o <= 1'b0;
    end
  end

  assign level_o = level;

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Upstream stage of the FIR filter / sigma-delta DAC chain.
- Accepts signed BW-bit PCM samples over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample every RATE_DIV clocks, with a one-cycle strobe, into the filter input.
- Decouples the bursty host/pin-loading rate from the fixed oversampled DAC rate, and reports underruns.

Parameters:
- BW, 16, sample width in bits (two's complement).
- DEPTH, 8, FIFO depth; power of two, ≥4.
- PREFILL, 4, FIFO level required before playback starts; 1..DEPTH.
- RATE_DIV, 64, clocks per output sample; ≥2.

Ports:
- clk  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- in_data_i  in  BW  signed input sample.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  feeder can accept a sample this cycle.
- flush_i  in  1  synchronous flush: empty FIFO, return to PRIME.
- clr_underflow_i  in  1  clears sticky underflow flag.
- sample_o  out  BW  signed sample to the FIR filter input.
- sample_strobe_o  out  1  one-cycle pulse, sample_o updated this cycle.
- underflow_o  out  1  sticky: a tick occurred in RUN with the FIFO empty.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (clk edge with rst_i=1):
  - sample_o=0, sample_strobe_o=0, underflow_o=0, level_o=0.
  - Rate counter=0, state=PRIME.
  - in_ready_o=0 while rst_i=1.
- Handshake:
  - in_ready_o = !rst_i && !flush_i && (level < DEPTH), combinational.
  - A push occurs on an edge where in_valid_i && in_ready_o.
  - in_data_i must be held while in_valid_i=1 && in_ready_o=0.
- Rate counter:
  - Counts 0..RATE_DIV-1 and wraps; free-running from reset, unaffected by state or flush.
  - tick = (cnt == RATE_DIV-1).
  - First tick falls RATE_DIV-1 cycles after the first non-reset edge.
- FSM:
  - PRIME:
    - Ticks do not pop and never set underflow.
    - Ticks still pulse sample_strobe_o, with sample_o held at 0.
    - PRIME→RUN on the first edge where level ≥ PREFILL.
  - RUN:
    - On tick with level>0: pop head; sample_o←head on that edge; sample_strobe_o=1 in the following cycle.
    - On tick with level=0: sample_o holds its previous value; strobe still pulses; underflow_o←1; state stays RUN.
- Latency: in RUN, a sample pushed into an empty FIFO on edge t appears on sample_o at the first tick edge strictly after t. There is no fall-through.
- Simultaneous push and pop (level>0): level unchanged, FIFO order preserved.
- Push on the same edge as a tick with level=0: counts as underflow; the pushed word is retained for the next tick.
- Full: in_ready_o=0. A pop on that edge frees a slot only from the next cycle.
- flush_i (any state, any cycle):
  - On that edge: level←0, state←PRIME, sample_o←0.
  - Any push on the flush edge is discarded, because in_ready_o=0.
  - A tick coincident with flush gives strobe=1 with sample_o=0.
  - underflow_o is not cleared by flush.
- clr_underflow_i clears underflow_o on that edge. If a new underflow occurs on the same edge, set wins.
- Reset mid-operation: all state returns to reset values on the next edge regardless of FSM state. FIFO contents are discarded.
- Widths: the sample path is a pure register move with no arithmetic; sign is preserved bit-exact. level_o saturates structurally at DEPTH.

Decomposition:
- Shared package (dac_pkg) holds:
  - FSM state encoding, PRIME=0 and RUN=1.
  - Default BW=16.
  - Helper constant for counter width, $clog2(RATE_DIV).
- One natural sub-module: dac_sync_fifo.
  - Parameters BW and DEPTH.
  - push/pop/data/level interface, synchronous clear, no fall-through.
  - The feeder top holds the rate counter, FSM and flags.

Test Plan (DEPTH=8, PREFILL=4, RATE_DIV=4):
- Prime/start: push 0x0001,0x0002,0x0003,0x0004 back-to-back after reset → strobes every 4 cycles with sample_o=0 until RUN; subsequent strobes deliver 0x0001..0x0004 in order; underflow_o=0.
- Full: push 9 words with no ticks popping (hold in PRIME by pushing ≥8 before the first RUN tick) → in_ready_o=0 at level_o=8; the 9th word is accepted only after a pop; no data loss or duplication.
- Underrun: stop pushing after 4 words in RUN → the 5th strobe keeps sample_o=0x0004 and underflow_o=1; it stays 1 until clr_underflow_i pulses, then 0.
- Sign: push 0x8000 and 0x7FFF → sample_o shows 0x8000 then 0x7FFF bit-exact.
- Flush mid-stream: level_o=5 in RUN, assert flush_i for 1 cycle → level_o=0, sample_o=0, state PRIME, underflow_o unchanged; playback resumes only after 4 new pushes.
- Reset mid-operation: assert rst_i with level_o=6 → next cycle all outputs are at reset values; first strobe occurs 4 cycles after release.
